iob_ibex_axi_arbiter: RTL and testbench
=======================================

# iob_ibex_axi_arbiter

Shares a single AXI4 master port between the Ibex instruction-fetch and data (LSU) request interfaces. It runs one outstanding transaction at a time, arbitrates between the two requesters round-robin, and sequences the AR/R or AW/W/B channels for each accepted request. It sits between the Ibex core and the SoC AXI interconnect, in place of per-port bridges.

## Interface
- ADDR_W, 32, byte address width on both Ibex and AXI sides
- DATA_W, 32, data width (fixed 32; wstrb is DATA_W/8)
- AXI_ID_W, 1, AXI ID width; ID 0 = instruction, 1 = data
- clk_i  in  1  clock; all logic on rising edge
- rst_n_i  in  1  synchronous, active-low reset
- cke_i  in  1  clock enable; state holds when low
- instr_req_i / instr_gnt_o / instr_rvalid_o / instr_err_o  in/out/out/out  1  fetch handshake
- instr_addr_i  in  ADDR_W  fetch address
- instr_rdata_o  out  DATA_W  fetch data
- data_req_i / data_we_i  in  1  LSU request, write enable
- data_be_i  in  4  byte enables
- data_addr_i  in  ADDR_W; data_wdata_i  in  DATA_W
- data_gnt_o / data_rvalid_o / data_err_o  out  1; data_rdata_o  out  DATA_W
- AXI AW: awvalid_o, awready_i, awaddr_o[ADDR_W], awid_o[AXI_ID_W], awprot_o[3], awlen_o[8], awsize_o[3], awburst_o[2]
- AXI W: wvalid_o, wready_i, wdata_o[DATA_W], wstrb_o[4], wlast_o
- AXI B: bvalid_i, bready_o, bresp_i[2], bid_i[AXI_ID_W]
- AXI AR: arvalid_o, arready_i, araddr_o[ADDR_W], arid_o, arprot_o[3], arlen_o[8], arsize_o[3], arburst_o[2]
- AXI R: rvalid_i, rready_o, rdata_i[DATA_W], rresp_i[2], rid_i, rlast_i

## Operation
- Constants: a*len_o = 0, a*size_o = 3'b010, a*burst_o = 2'b01, wlast_o = 1. awprot_o = 3'b000. arprot_o = 3'b100 for instruction, 3'b000 for data.
- FSM states: IDLE, AR, R, AW_W, B, RSP.
- IDLE:
  - Grant is combinational: exactly one of instr_gnt_o/data_gnt_o is high when any req_i is high.
  - Both requesting: the grant goes to the port that is not last_owner. last_owner resets to DATA, so the first tie after reset goes to instruction.
  - On a grant, capture owner, addr, we, be and wdata, and set last_owner = owner.
  - Next state is AW_W for a data write; otherwise AR.
- AR: arvalid_o = 1, araddr/arid from the captured values. On arready_i, go to R.
- R: rready_o = 1. On rvalid_i, capture rdata_i and set err = (rresp_i != 2'b00), then go to RSP.
- AW_W:
  - awvalid_o and wvalid_o are both raised. Each drops independently after its own handshake, tracked by aw_done/w_done flags.
  - Go to B once both handshakes are done; a same-cycle handshake on both is allowed.
- B: bready_o = 1. On bvalid_i, set err = (bresp_i != 2'b00) and go to RSP.
- RSP:
  - Pulse the owner's rvalid_o for 1 cycle, with rdata_o (reads) and err_o valid in that cycle. Return to IDLE.
  - Gnt is never issued in RSP.
- Response steering: rdata_o to the non-owner port is don't-care but driven from the same register; rvalid_o/err_o to the non-owner port are 0.
- rid_i, bid_i and rlast_i are ignored; routing uses the captured owner.
- Instruction requests are always reads.

## Timing
- Reset, or any cycle with rst_n_i = 0 at the edge: state IDLE, all valid/ready/gnt/rvalid/err outputs 0, aw_done/w_done cleared, last_owner = DATA. A reset mid-transaction abandons the AXI transaction; no response is returned to Ibex.
- Read latency with a zero-wait slave:
  - Gnt in cycle T; arvalid_o from T+1.
  - With arready_i in T+1 and rvalid_i in T+2, Ibex rvalid is in T+3.
- Write latency: gnt T; aw/w in T+1; bvalid_i in T+2; Ibex rvalid in T+3.
- Valids are held stable until ready. Address, data and strobe are unchanged while valid.
- Ibex req changes outside IDLE are ignored; a pending req is granted on the first IDLE cycle.
- cke_i = 0 freezes state and registers. Combinational gnt is also forced to 0.

## Test plan
- Single fetch: instr_req, addr 0x0000_1000; slave returns rdata 0xDEADBEEF, OKAY → arprot 3'b100, arid 0, instr_rvalid with 0xDEADBEEF at T+3, err 0.
- Data write: addr 0x20, be 4'b0011, wdata 0x1234_5678; wready arrives 3 cycles after awready → awvalid drops after its handshake, wvalid held, wstrb 4'b0011, single data_rvalid after B.
- Tie: both ports request continuously for 4 transactions → grant order instr, data, instr, data; gnt never in AR/R/AW_W/B/RSP.
- Error: read returns rresp 2'b10 → data_rvalid = data_err = 1 for one cycle; instr_err stays 0.
- Backpressure: arready low 5 cycles → arvalid and araddr stable throughout, no second grant.
- Reset mid-write in AW_W → next cycle all AXI valids 0, state IDLE, no rvalid; next request granted to instruction on a tie.

Source files
------------

// File: rtl/iob_ibex_axi_arbiter_if.sv
// Bus bundle between the Ibex instruction/data request ports and the shared AXI4 master port.
interface iob_ibex_axi_arbiter_if #(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned AXI_ID_W = 1
);
    // Ibex instruction fetch port
    logic                instr_req_i;
    logic                instr_gnt_o;
    logic                instr_rvalid_o;
    logic                instr_err_o;
    logic [ADDR_W-1:0]   instr_addr_i;
    logic [DATA_W-1:0]   instr_rdata_o;

    // Ibex LSU port
    logic                data_req_i;
    logic                data_we_i;
    logic [3:0]          data_be_i;
    logic [ADDR_W-1:0]   data_addr_i;
    logic [DATA_W-1:0]   data_wdata_i;
    logic                data_gnt_o;
    logic                data_rvalid_o;
    logic                data_err_o;
    logic [DATA_W-1:0]   data_rdata_o;

    // AXI write address
    logic                awvalid_o;
    logic                awready_i;
    logic [ADDR_W-1:0]   awaddr_o;
    logic [AXI_ID_W-1:0] awid_o;
    logic [2:0]          awprot_o;
    logic [7:0]          awlen_o;
    logic [2:0]          awsize_o;
    logic [1:0]          awburst_o;

    // AXI write data
    logic                wvalid_o;
    logic                wready_i;
    logic [DATA_W-1:0]   wdata_o;
    logic [3:0]          wstrb_o;
    logic                wlast_o;

    // AXI write response
    logic                bvalid_i;
    logic                bready_o;
    logic [1:0]          bresp_i;
    logic [AXI_ID_W-1:0] bid_i;

    // AXI read address
    logic                arvalid_o;
    logic                arready_i;
    logic [ADDR_W-1:0]   araddr_o;
    logic [AXI_ID_W-1:0] arid_o;
    logic [2:0]          arprot_o;
    logic [7:0]          arlen_o;
    logic [2:0]          arsize_o;
    logic [1:0]          arburst_o;

    // AXI read data
    logic                rvalid_i;
    logic                rready_o;
    logic [DATA_W-1:0]   rdata_i;
    logic [1:0]          rresp_i;
    logic [AXI_ID_W-1:0] rid_i;
    logic                rlast_i;

    // Arbiter view: receives Ibex requests and AXI responses
    modport master (
        input  instr_req_i, instr_addr_i,
        output instr_gnt_o, instr_rvalid_o, instr_err_o, instr_rdata_o,
        input  data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
        output data_gnt_o, data_rvalid_o, data_err_o, data_rdata_o,
        output awvalid_o, awaddr_o, awid_o, awprot_o, awlen_o, awsize_o, awburst_o,
        input  awready_i,
        output wvalid_o, wdata_o, wstrb_o, wlast_o,
        input  wready_i,
        input  bvalid_i, bresp_i, bid_i,
        output bready_o,
        output arvalid_o, araddr_o, arid_o, arprot_o, arlen_o, arsize_o, arburst_o,
        input  arready_i,
        input  rvalid_i, rdata_i, rresp_i, rid_i, rlast_i,
        output rready_o
    );

    // Environment view: Ibex core plus AXI slave
    modport slave (
        output instr_req_i, instr_addr_i,
        input  instr_gnt_o, instr_rvalid_o, instr_err_o, instr_rdata_o,
        output data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
        input  data_gnt_o, data_rvalid_o, data_err_o, data_rdata_o,
        input  awvalid_o, awaddr_o, awid_o, awprot_o, awlen_o, awsize_o, awburst_o,
        output awready_i,
        input  wvalid_o, wdata_o, wstrb_o, wlast_o,
        output wready_i,
        output bvalid_i, bresp_i, bid_i,
        input  bready_o,
        input  arvalid_o, araddr_o, arid_o, arprot_o, arlen_o, arsize_o, arburst_o,
        output arready_i,
        output rvalid_i, rdata_i, rresp_i, rid_i, rlast_i,
        input  rready_o
    );
endinterface

// File: rtl/iob_ibex_axi_arbiter.sv
// Round-robin arbiter sharing one AXI4 master port between Ibex fetch and LSU, one transaction in flight.
module iob_ibex_axi_arbiter (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic                   cke_i,
    iob_ibex_axi_arbiter_if.master bus
);
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = 4;

    localparam logic OWNER_INSTR = 1'b0;
    localparam logic OWNER_DATA  = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_AR,
        ST_R,
        ST_AW_W,
        ST_B,
        ST_RSP
    } state_t;

    state_t            state_q, state_d;
    logic              owner_q, owner_d;
    logic              last_owner_q, last_owner_d;
    logic              we_q, we_d;
    logic              aw_done_q, aw_done_d;
    logic              w_done_q, w_done_d;
    logic              err_q, err_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [BE_W-1:0]   be_q, be_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic arvalid_q, arvalid_d;
    logic rready_q, rready_d;
    logic awvalid_q, awvalid_d;
    logic wvalid_q, wvalid_d;
    logic bready_q, bready_d;
    logic instr_rvalid_q, instr_rvalid_d;
    logic data_rvalid_q, data_rvalid_d;
    logic instr_err_q, instr_err_d;
    logic data_err_q, data_err_d;

    logic grant_c;
    logic sel_data_c;
    logic unused_c;

    // Routing uses the captured owner, so response IDs and rlast carry no information here
    assign unused_c = ^{bus.rid_i, bus.bid_i, bus.rlast_i};

    // Round-robin pick: on a tie the port that did not win last time gets the grant
    always_comb begin
        sel_data_c = bus.data_req_i;
        if (bus.instr_req_i && bus.data_req_i) begin
            sel_data_c = (last_owner_q == OWNER_INSTR);
        end
    end

    assign grant_c = rst_n_i && cke_i && (state_q == ST_IDLE)
                   && (bus.instr_req_i || bus.data_req_i);

    assign bus.instr_gnt_o = grant_c && !sel_data_c;
    assign bus.data_gnt_o  = grant_c && sel_data_c;

    // Next-state, captured request/response fields and next values of the registered outputs
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        we_d         = we_q;
        aw_done_d    = aw_done_q;
        w_done_d     = w_done_q;
        err_d        = err_q;
        addr_d       = addr_q;
        be_d         = be_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;

        case (state_q)
            ST_IDLE: begin
                if (grant_c) begin
                    owner_d      = sel_data_c;
                    last_owner_d = sel_data_c;
                    addr_d       = sel_data_c ? bus.data_addr_i : bus.instr_addr_i;
                    we_d         = sel_data_c && bus.data_we_i;
                    be_d         = bus.data_be_i;
                    wdata_d      = bus.data_wdata_i;
                    state_d      = we_d ? ST_AW_W : ST_AR;
                end
            end
            ST_AR: begin
                if (bus.arready_i) begin
                    state_d = ST_R;
                end
            end
            ST_R: begin
                if (bus.rvalid_i) begin
                    rdata_d = bus.rdata_i;
                    err_d   = (bus.rresp_i != 2'b00);
                    state_d = ST_RSP;
                end
            end
            ST_AW_W: begin
                aw_done_d = aw_done_q || (awvalid_q && bus.awready_i);
                w_done_d  = w_done_q || (wvalid_q && bus.wready_i);
                if (aw_done_d && w_done_d) begin
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = ST_B;
                end
            end
            ST_B: begin
                if (bus.bvalid_i) begin
                    err_d   = (bus.bresp_i != 2'b00);
                    state_d = ST_RSP;
                end
            end
            ST_RSP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        arvalid_d      = (state_d == ST_AR);
        rready_d       = (state_d == ST_R);
        awvalid_d      = (state_d == ST_AW_W) && !aw_done_d;
        wvalid_d       = (state_d == ST_AW_W) && !w_done_d;
        bready_d       = (state_d == ST_B);
        instr_rvalid_d = (state_d == ST_RSP) && (owner_d == OWNER_INSTR);
        data_rvalid_d  = (state_d == ST_RSP) && (owner_d == OWNER_DATA);
        instr_err_d    = instr_rvalid_d && err_d;
        data_err_d     = data_rvalid_d && err_d;
    end

    // State and capture registers; reset abandons any transaction, cke_i low freezes everything
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q        <= ST_IDLE;
            owner_q        <= OWNER_INSTR;
            last_owner_q   <= OWNER_DATA;
            we_q           <= 1'b0;
            aw_done_q      <= 1'b0;
            w_done_q       <= 1'b0;
            err_q          <= 1'b0;
            addr_q         <= '0;
            be_q           <= '0;
            wdata_q        <= '0;
            rdata_q        <= '0;
            arvalid_q      <= 1'b0;
            rready_q       <= 1'b0;
            awvalid_q      <= 1'b0;
            wvalid_q       <= 1'b0;
            bready_q       <= 1'b0;
            instr_rvalid_q <= 1'b0;
            data_rvalid_q  <= 1'b0;
            instr_err_q    <= 1'b0;
            data_err_q     <= 1'b0;
        end else if (cke_i) begin
            state_q        <= state_d;
            owner_q        <= owner_d;
            last_owner_q   <= last_owner_d;
            we_q           <= we_d;
            aw_done_q      <= aw_done_d;
            w_done_q       <= w_done_d;
            err_q          <= err_d;
            addr_q         <= addr_d;
            be_q           <= be_d;
            wdata_q        <= wdata_d;
            rdata_q        <= rdata_d;
            arvalid_q      <= arvalid_d;
            rready_q       <= rready_d;
            awvalid_q      <= awvalid_d;
            wvalid_q       <= wvalid_d;
            bready_q       <= bready_d;
            instr_rvalid_q <= instr_rvalid_d;
            data_rvalid_q  <= data_rvalid_d;
            instr_err_q    <= instr_err_d;
            data_err_q     <= data_err_d;
        end
    end

    assign bus.awvalid_o = awvalid_q;
    assign bus.awaddr_o  = addr_q;
    assign bus.awid_o    = OWNER_DATA;
    assign bus.awprot_o  = 3'b000;
    assign bus.awlen_o   = 8'd0;
    assign bus.awsize_o  = 3'b010;
    assign bus.awburst_o = 2'b01;

    assign bus.wvalid_o = wvalid_q;
    assign bus.wdata_o  = wdata_q;
    assign bus.wstrb_o  = be_q;
    assign bus.wlast_o  = 1'b1;

    assign bus.bready_o = bready_q;

    assign bus.arvalid_o = arvalid_q;
    assign bus.araddr_o  = addr_q;
    assign bus.arid_o    = owner_q;
    assign bus.arprot_o  = (owner_q == OWNER_INSTR) ? 3'b100 : 3'b000;
    assign bus.arlen_o   = 8'd0;
    assign bus.arsize_o  = 3'b010;
    assign bus.arburst_o = 2'b01;

    assign bus.rready_o = rready_q;

    assign bus.instr_rvalid_o = instr_rvalid_q;
    assign bus.instr_err_o    = instr_err_q;
    assign bus.instr_rdata_o  = rdata_q;
    assign bus.data_rvalid_o  = data_rvalid_q;
    assign bus.data_err_o     = data_err_q;
    assign bus.data_rdata_o   = rdata_q;
endmodule

// File: tb/tb_iob_ibex_axi_arbiter.sv
// Directed bench for iob_ibex_axi_arbiter: inputs change on the falling edge, outputs are checked there too.
module tb_iob_ibex_axi_arbiter;
    logic clk;
    logic rst_n;
    logic cke;
    int   vectors;
    int   miscompares;

    iob_ibex_axi_arbiter_if bus ();

    iob_ibex_axi_arbiter dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .cke_i   (cke),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.instr_req_i = 1'b1;
        tick();
        tick();
        #1;
        vectors++; if (bus.instr_gnt_o !== 1'b0) begin miscompares++; $display("FAIL rst_instr_gnt: got %b want 0", bus.instr_gnt_o); end
        vectors++; if (bus.arvalid_o !== 1'b0) begin miscompares++; $display("FAIL rst_arvalid: got %b want 0", bus.arvalid_o); end
        vectors++; if (bus.awvalid_o !== 1'b0 || bus.wvalid_o !== 1'b0) begin miscompares++; $display("FAIL rst_aw_w: got %b%b want 00", bus.awvalid_o, bus.wvalid_o); end
        vectors++; if (bus.rready_o !== 1'b0 || bus.bready_o !== 1'b0) begin miscompares++; $display("FAIL rst_ready: got %b%b want 00", bus.rready_o, bus.bready_o); end
        vectors++; if (bus.instr_rvalid_o !== 1'b0 || bus.data_rvalid_o !== 1'b0) begin miscompares++; $display("FAIL rst_rvalid: got %b%b want 00", bus.instr_rvalid_o, bus.data_rvalid_o); end
        bus.instr_req_i = 1'b0;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_fetch();
        bus.instr_req_i  = 1'b1;
        bus.instr_addr_i = 32'h0000_1000;
        #1;
        vectors++; if (bus.instr_gnt_o !== 1'b1 || bus.data_gnt_o !== 1'b0) begin miscompares++; $display("FAIL fetch_gnt: got %b%b want 10", bus.instr_gnt_o, bus.data_gnt_o); end
        tick();
        bus.instr_req_i = 1'b0;
        vectors++; if (bus.arvalid_o !== 1'b1) begin miscompares++; $display("FAIL fetch_arvalid: got %b want 1", bus.arvalid_o); end
        vectors++; if (bus.araddr_o !== 32'h0000_1000) begin miscompares++; $display("FAIL fetch_araddr: got %h want 00001000", bus.araddr_o); end
        vectors++; if (bus.arid_o !== 1'b0 || bus.arprot_o !== 3'b100) begin miscompares++; $display("FAIL fetch_arid_prot: got %b/%b want 0/100", bus.arid_o, bus.arprot_o); end
        vectors++; if (bus.arlen_o !== 8'd0 || bus.arsize_o !== 3'b010 || bus.arburst_o !== 2'b01) begin miscompares++; $display("FAIL fetch_arconst: got %h/%b/%b want 00/010/01", bus.arlen_o, bus.arsize_o, bus.arburst_o); end
        bus.arready_i = 1'b1;
        tick();
        bus.arready_i = 1'b0;
        vectors++; if (bus.rready_o !== 1'b1 || bus.arvalid_o !== 1'b0) begin miscompares++; $display("FAIL fetch_rready: got rready %b arvalid %b want 1 0", bus.rready_o, bus.arvalid_o); end
        bus.rvalid_i = 1'b1;
        bus.rdata_i  = 32'hDEAD_BEEF;
        bus.rresp_i  = 2'b00;
        tick();
        bus.rvalid_i = 1'b0;
        vectors++; if (bus.instr_rvalid_o !== 1'b1 || bus.data_rvalid_o !== 1'b0) begin miscompares++; $display("FAIL fetch_rvalid: got %b%b want 10", bus.instr_rvalid_o, bus.data_rvalid_o); end
        vectors++; if (bus.instr_rdata_o !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL fetch_rdata: got %h want deadbeef", bus.instr_rdata_o); end
        vectors++; if (bus.instr_err_o !== 1'b0) begin miscompares++; $display("FAIL fetch_err: got %b want 0", bus.instr_err_o); end
        tick();
        vectors++; if (bus.instr_rvalid_o !== 1'b0) begin miscompares++; $display("FAIL fetch_rvalid_pulse: got %b want 0", bus.instr_rvalid_o); end
    endtask

    task automatic test_write();
        bus.data_req_i   = 1'b1;
        bus.data_we_i    = 1'b1;
        bus.data_be_i    = 4'b0011;
        bus.data_addr_i  = 32'h0000_0020;
        bus.data_wdata_i = 32'h1234_5678;
        #1;
        vectors++; if (bus.data_gnt_o !== 1'b1 || bus.instr_gnt_o !== 1'b0) begin miscompares++; $display("FAIL wr_gnt: got %b%b want 01", bus.data_gnt_o, bus.instr_gnt_o); end
        tick();
        bus.data_req_i = 1'b0;
        bus.data_we_i  = 1'b0;
        vectors++; if (bus.awvalid_o !== 1'b1 || bus.wvalid_o !== 1'b1) begin miscompares++; $display("FAIL wr_valids: got %b%b want 11", bus.awvalid_o, bus.wvalid_o); end
        vectors++; if (bus.awaddr_o !== 32'h0000_0020 || bus.awid_o !== 1'b1 || bus.awprot_o !== 3'b000) begin miscompares++; $display("FAIL wr_aw: got %h/%b/%b want 00000020/1/000", bus.awaddr_o, bus.awid_o, bus.awprot_o); end
        vectors++; if (bus.wdata_o !== 32'h1234_5678 || bus.wstrb_o !== 4'b0011 || bus.wlast_o !== 1'b1) begin miscompares++; $display("FAIL wr_w: got %h/%b/%b want 12345678/0011/1", bus.wdata_o, bus.wstrb_o, bus.wlast_o); end
        bus.awready_i = 1'b1;
        tick();
        bus.awready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            vectors++; if (bus.awvalid_o !== 1'b0 || bus.wvalid_o !== 1'b1 || bus.bready_o !== 1'b0) begin miscompares++; $display("FAIL wr_wait%0d: got aw %b w %b b %b want 0 1 0", i, bus.awvalid_o, bus.wvalid_o, bus.bready_o); end
            vectors++; if (bus.wstrb_o !== 4'b0011) begin miscompares++; $display("FAIL wr_wstrb_hold%0d: got %b want 0011", i, bus.wstrb_o); end
            if (i == 2) bus.wready_i = 1'b1;
            tick();
        end
        bus.wready_i = 1'b0;
        vectors++; if (bus.wvalid_o !== 1'b0 || bus.bready_o !== 1'b1) begin miscompares++; $display("FAIL wr_bready: got w %b b %b want 0 1", bus.wvalid_o, bus.bready_o); end
        bus.bvalid_i = 1'b1;
        bus.bresp_i  = 2'b00;
        bus.bid_i    = 1'b1;
        tick();
        bus.bvalid_i = 1'b0;
        vectors++; if (bus.data_rvalid_o !== 1'b1 || bus.instr_rvalid_o !== 1'b0 || bus.data_err_o !== 1'b0) begin miscompares++; $display("FAIL wr_rsp: got rv %b irv %b err %b want 1 0 0", bus.data_rvalid_o, bus.instr_rvalid_o, bus.data_err_o); end
        tick();
        vectors++; if (bus.data_rvalid_o !== 1'b0) begin miscompares++; $display("FAIL wr_rsp_pulse: got %b want 0", bus.data_rvalid_o); end
    endtask

    task automatic test_tie();
        logic exp_data;
        bus.instr_req_i  = 1'b1;
        bus.instr_addr_i = 32'h0000_0100;
        bus.data_req_i   = 1'b1;
        bus.data_we_i    = 1'b0;
        bus.data_addr_i  = 32'h0000_0400;
        for (int i = 0; i < 4; i++) begin
            exp_data = (i % 2 == 1);
            #1;
            vectors++; if (bus.instr_gnt_o !== !exp_data || bus.data_gnt_o !== exp_data) begin miscompares++; $display("FAIL tie_gnt%0d: got %b%b want %b%b", i, bus.instr_gnt_o, bus.data_gnt_o, !exp_data, exp_data); end
            tick();
            vectors++; if (bus.instr_gnt_o !== 1'b0 || bus.data_gnt_o !== 1'b0) begin miscompares++; $display("FAIL tie_gnt_ar%0d: got %b%b want 00", i, bus.instr_gnt_o, bus.data_gnt_o); end
            vectors++; if (bus.arid_o !== exp_data || bus.araddr_o !== (exp_data ? 32'h0000_0400 : 32'h0000_0100)) begin miscompares++; $display("FAIL tie_ar%0d: got id %b addr %h", i, bus.arid_o, bus.araddr_o); end
            bus.arready_i = 1'b1;
            tick();
            bus.arready_i = 1'b0;
            vectors++; if (bus.instr_gnt_o !== 1'b0 || bus.data_gnt_o !== 1'b0) begin miscompares++; $display("FAIL tie_gnt_r%0d: got %b%b want 00", i, bus.instr_gnt_o, bus.data_gnt_o); end
            bus.rvalid_i = 1'b1;
            bus.rdata_i  = 32'h0000_00A0 + 32'(i);
            tick();
            bus.rvalid_i = 1'b0;
            vectors++; if (bus.instr_gnt_o !== 1'b0 || bus.data_gnt_o !== 1'b0) begin miscompares++; $display("FAIL tie_gnt_rsp%0d: got %b%b want 00", i, bus.instr_gnt_o, bus.data_gnt_o); end
            vectors++; if (bus.instr_rvalid_o !== !exp_data || bus.data_rvalid_o !== exp_data) begin miscompares++; $display("FAIL tie_rvalid%0d: got %b%b want %b%b", i, bus.instr_rvalid_o, bus.data_rvalid_o, !exp_data, exp_data); end
            vectors++; if (bus.data_rdata_o !== 32'h0000_00A0 + 32'(i)) begin miscompares++; $display("FAIL tie_rdata%0d: got %h want %h", i, bus.data_rdata_o, 32'h0000_00A0 + 32'(i)); end
            tick();
        end
        bus.instr_req_i = 1'b0;
        bus.data_req_i  = 1'b0;
    endtask

    task automatic test_error();
        bus.data_req_i  = 1'b1;
        bus.data_we_i   = 1'b0;
        bus.data_addr_i = 32'h0000_0044;
        #1;
        vectors++; if (bus.data_gnt_o !== 1'b1) begin miscompares++; $display("FAIL err_gnt: got %b want 1", bus.data_gnt_o); end
        tick();
        bus.data_req_i = 1'b0;
        bus.arready_i  = 1'b1;
        tick();
        bus.arready_i = 1'b0;
        bus.rvalid_i  = 1'b1;
        bus.rresp_i   = 2'b10;
        tick();
        bus.rvalid_i = 1'b0;
        bus.rresp_i  = 2'b00;
        vectors++; if (bus.data_rvalid_o !== 1'b1 || bus.data_err_o !== 1'b1) begin miscompares++; $display("FAIL err_rsp: got rv %b err %b want 1 1", bus.data_rvalid_o, bus.data_err_o); end
        vectors++; if (bus.instr_err_o !== 1'b0 || bus.instr_rvalid_o !== 1'b0) begin miscompares++; $display("FAIL err_instr: got err %b rv %b want 0 0", bus.instr_err_o, bus.instr_rvalid_o); end
        tick();
        vectors++; if (bus.data_rvalid_o !== 1'b0 || bus.data_err_o !== 1'b0) begin miscompares++; $display("FAIL err_pulse: got rv %b err %b want 0 0", bus.data_rvalid_o, bus.data_err_o); end
    endtask

    task automatic test_backpressure();
        bus.instr_req_i  = 1'b1;
        bus.instr_addr_i = 32'h0000_2000;
        bus.data_req_i   = 1'b1;
        bus.data_we_i    = 1'b0;
        bus.data_addr_i  = 32'h0000_0500;
        #1;
        vectors++; if (bus.instr_gnt_o !== 1'b1 || bus.data_gnt_o !== 1'b0) begin miscompares++; $display("FAIL bp_gnt: got %b%b want 10", bus.instr_gnt_o, bus.data_gnt_o); end
        tick();
        bus.instr_addr_i = 32'h0000_3000;
        for (int i = 0; i < 5; i++) begin
            #1;
            vectors++; if (bus.arvalid_o !== 1'b1 || bus.araddr_o !== 32'h0000_2000) begin miscompares++; $display("FAIL bp_hold%0d: got valid %b addr %h want 1 00002000", i, bus.arvalid_o, bus.araddr_o); end
            vectors++; if (bus.instr_gnt_o !== 1'b0 || bus.data_gnt_o !== 1'b0) begin miscompares++; $display("FAIL bp_nogrant%0d: got %b%b want 00", i, bus.instr_gnt_o, bus.data_gnt_o); end
            tick();
        end
        bus.arready_i = 1'b1;
        tick();
        bus.arready_i   = 1'b0;
        bus.instr_req_i = 1'b0;
        bus.data_req_i  = 1'b0;
        bus.rvalid_i    = 1'b1;
        bus.rdata_i     = 32'h0000_0055;
        tick();
        bus.rvalid_i = 1'b0;
        vectors++; if (bus.instr_rvalid_o !== 1'b1 || bus.instr_rdata_o !== 32'h0000_0055) begin miscompares++; $display("FAIL bp_rsp: got rv %b data %h want 1 00000055", bus.instr_rvalid_o, bus.instr_rdata_o); end
        tick();
    endtask

    task automatic test_cke();
        bus.instr_req_i  = 1'b1;
        bus.instr_addr_i = 32'h0000_0600;
        cke = 1'b0;
        #1;
        vectors++; if (bus.instr_gnt_o !== 1'b0 || bus.data_gnt_o !== 1'b0) begin miscompares++; $display("FAIL cke_gnt_off: got %b%b want 00", bus.instr_gnt_o, bus.data_gnt_o); end
        tick();
        cke = 1'b1;
        #1;
        vectors++; if (bus.instr_gnt_o !== 1'b1) begin miscompares++; $display("FAIL cke_gnt_on: got %b want 1", bus.instr_gnt_o); end
        tick();
        bus.instr_req_i = 1'b0;
        bus.arready_i   = 1'b1;
        cke = 1'b0;
        tick();
        vectors++; if (bus.arvalid_o !== 1'b1 || bus.rready_o !== 1'b0) begin miscompares++; $display("FAIL cke_freeze: got arvalid %b rready %b want 1 0", bus.arvalid_o, bus.rready_o); end
        cke = 1'b1;
        tick();
        bus.arready_i = 1'b0;
        vectors++; if (bus.rready_o !== 1'b1) begin miscompares++; $display("FAIL cke_resume: got rready %b want 1", bus.rready_o); end
        bus.rvalid_i = 1'b1;
        bus.rdata_i  = 32'hCAFE_0001;
        tick();
        bus.rvalid_i = 1'b0;
        vectors++; if (bus.instr_rvalid_o !== 1'b1 || bus.instr_rdata_o !== 32'hCAFE_0001) begin miscompares++; $display("FAIL cke_rsp: got rv %b data %h want 1 cafe0001", bus.instr_rvalid_o, bus.instr_rdata_o); end
        tick();
    endtask

    task automatic test_reset_mid_write();
        bus.data_req_i   = 1'b1;
        bus.data_we_i    = 1'b1;
        bus.data_be_i    = 4'b1111;
        bus.data_addr_i  = 32'h0000_0080;
        bus.data_wdata_i = 32'hA5A5_A5A5;
        tick();
        bus.data_req_i = 1'b0;
        bus.data_we_i  = 1'b0;
        vectors++; if (bus.awvalid_o !== 1'b1) begin miscompares++; $display("FAIL rmw_awvalid: got %b want 1", bus.awvalid_o); end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        vectors++; if (bus.awvalid_o !== 1'b0 || bus.wvalid_o !== 1'b0 || bus.arvalid_o !== 1'b0) begin miscompares++; $display("FAIL rmw_valids: got aw %b w %b ar %b want 0 0 0", bus.awvalid_o, bus.wvalid_o, bus.arvalid_o); end
        vectors++; if (bus.data_rvalid_o !== 1'b0 || bus.bready_o !== 1'b0) begin miscompares++; $display("FAIL rmw_norsp: got rv %b bready %b want 0 0", bus.data_rvalid_o, bus.bready_o); end
        bus.instr_req_i  = 1'b1;
        bus.instr_addr_i = 32'h0000_0700;
        bus.data_req_i   = 1'b1;
        #1;
        vectors++; if (bus.instr_gnt_o !== 1'b1 || bus.data_gnt_o !== 1'b0) begin miscompares++; $display("FAIL rmw_tie: got %b%b want 10", bus.instr_gnt_o, bus.data_gnt_o); end
        tick();
        // Abandon the fetch too; the tie must again favour instruction after reset
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
        vectors++; if (bus.instr_gnt_o !== 1'b1 || bus.data_gnt_o !== 1'b0) begin miscompares++; $display("FAIL rmw_tie_again: got %b%b want 10", bus.instr_gnt_o, bus.data_gnt_o); end
        vectors++; if (bus.instr_rvalid_o !== 1'b0 || bus.arvalid_o !== 1'b0) begin miscompares++; $display("FAIL rmw_idle: got rv %b ar %b want 0 0", bus.instr_rvalid_o, bus.arvalid_o); end
        bus.instr_req_i = 1'b0;
        bus.data_req_i  = 1'b0;
        tick();
    endtask

    initial begin
        vectors          = 0;
        miscompares      = 0;
        rst_n            = 1'b0;
        cke              = 1'b1;
        bus.instr_req_i  = 1'b0;
        bus.instr_addr_i = '0;
        bus.data_req_i   = 1'b0;
        bus.data_we_i    = 1'b0;
        bus.data_be_i    = '0;
        bus.data_addr_i  = '0;
        bus.data_wdata_i = '0;
        bus.awready_i    = 1'b0;
        bus.wready_i     = 1'b0;
        bus.bvalid_i     = 1'b0;
        bus.bresp_i      = 2'b00;
        bus.bid_i        = 1'b0;
        bus.arready_i    = 1'b0;
        bus.rvalid_i     = 1'b0;
        bus.rdata_i      = '0;
        bus.rresp_i      = 2'b00;
        bus.rid_i        = 1'b0;
        bus.rlast_i      = 1'b1;
        @(negedge clk);

        test_reset();
        test_fetch();
        test_write();
        test_tie();
        test_error();
        test_backpressure();
        test_cke();
        test_reset_mid_write();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
